// File: rtl/serial_word_feeder.sv
// serial_word_feeder: serializes WIDTH-bit words accepted over valid/ready onto a registered serial line.
module serial_word_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             bit_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dout_q, dout_d, started_q, last, accept;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      dout_q    <= IDLE_BIT;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      started_q <= 1'b1;
    end
  // sr holds the bits not yet presented; dout_q is the bit currently on the line
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    last       = (state_q == SHIFT) && (cnt_q == LAST) && bit_en;
    load_ready = (state_q == IDLE) ? started_q : last;
    accept     = load_valid && load_ready;
    if (accept) begin
      state_d = SHIFT;
      cnt_d   = '0;
      dout_d  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
      sr_d    = MSB_FIRST ? data_in << 1 : data_in >> 1;
    end else if (last) begin
      state_d = IDLE;
      cnt_d   = '0;
      dout_d  = IDLE_BIT;
    end else if (state_q == SHIFT && bit_en) begin
      cnt_d  = cnt_q + CW'(1);
      dout_d = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
      sr_d   = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
    end
  end
  assign dout       = dout_q;
  assign dout_valid = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign word_done  = last;
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: directed vector table plus hand-written corner sequences for MSB- and LSB-first feeders.
module tb_serial_word_feeder;
  logic clk = 1'b0, reset = 1'b1, load_valid = 1'b0, bit_en = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic m_ready, m_dout, m_dv, m_busy, m_done;
  logic l_ready, l_dout, l_dv, l_busy, l_done;
  int total = 0, bad = 0;
  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid), .load_ready(m_ready),
    .bit_en(bit_en), .dout(m_dout), .dout_valid(m_dv), .busy(m_busy), .word_done(m_done));
  serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid), .load_ready(l_ready),
    .bit_en(bit_en), .dout(l_dout), .dout_valid(l_dv), .busy(l_busy), .word_done(l_done));
  always #5 clk = ~clk;
  typedef struct {
    logic v; logic [7:0] d; logic en;
    logic dout, dv, rdy, done, busy, y;
  } vec_t;
  vec_t tbl[$];
  logic [4:0] hist;
  logic [7:0] w;
  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void add(logic v, logic [7:0] d, logic en, logic dout, logic dv,
                              logic rdy, logic done, logic busy, logic y);
    vec_t r;
    r.v = v; r.d = d; r.en = en; r.dout = dout; r.dv = dv;
    r.rdy = rdy; r.done = done; r.busy = busy; r.y = y;
    tbl.push_back(r);
  endfunction
  task automatic shift_word(input string name, input logic [7:0] word);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk({name, "_dout"}, m_dout, word[7-i]);
      chk({name, "_dv"}, m_dv, 1'b1);
      chk({name, "_done"}, m_done, i == 7);
      tick();
    end
  endtask
  initial begin
    // single word 8'hCE
    add(1, 8'hCE, 1, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 1);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0);
    // back-to-back 8'hC9 then 8'h9C, 9C offered early must not be captured
    add(1, 8'hC9, 1, 0, 0, 1, 0, 0, 0);
    add(1, 8'h9C, 1, 1, 1, 0, 0, 1, 0);
    add(1, 8'h9C, 1, 1, 1, 0, 0, 1, 0);
    add(1, 8'h9C, 1, 0, 1, 0, 0, 1, 0);
    add(1, 8'h9C, 1, 0, 1, 0, 0, 1, 0);
    add(1, 8'h9C, 1, 1, 1, 0, 0, 1, 1);
    add(1, 8'h9C, 1, 0, 1, 0, 0, 1, 0);
    add(1, 8'h9C, 1, 0, 1, 0, 0, 1, 0);
    add(1, 8'h9C, 1, 1, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 1);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0);
    // 8'hF0 with a three-cycle stall after the second bit
    add(1, 8'hF0, 1, 0, 0, 1, 0, 0, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 0, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 0, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 0, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 0, 1, 1, 1, 1, 0);
    add(0, 8'h00, 1, 0, 0, 1, 0, 0, 0);
    #2;
    chk("rst_dout", m_dout, 1'b0);
    chk("rst_dv", m_dv, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_done", m_done, 1'b0);
    chk("rst_ready", m_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("rel_ready_pre", m_ready, 1'b0);
    tick();
    chk("rel_ready_post", m_ready, 1'b1);
    hist = '0;
    foreach (tbl[k]) begin
      load_valid = tbl[k].v;
      data_in    = tbl[k].d;
      bit_en     = tbl[k].en;
      #1;
      hist = m_dv ? {hist[3:0], m_dout} : 5'b0;
      chk($sformatf("vec%0d_dout", k), m_dout, tbl[k].dout);
      chk($sformatf("vec%0d_dv", k), m_dv, tbl[k].dv);
      chk($sformatf("vec%0d_ready", k), m_ready, tbl[k].rdy);
      chk($sformatf("vec%0d_done", k), m_done, tbl[k].done);
      chk($sformatf("vec%0d_busy", k), m_busy, tbl[k].busy);
      chk($sformatf("vec%0d_det11001", k), m_dv && hist == 5'b11001, tbl[k].y);
      tick();
    end
    // LSB-first word 8'h13 on the second instance
    w = 8'h13;
    load_valid = 1'b1;
    data_in = w;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("lsb_dout%0d", i), l_dout, w[i]);
      chk($sformatf("lsb_msbref%0d", i), m_dout, w[7-i]);
      chk($sformatf("lsb_dv%0d", i), l_dv, 1'b1);
      chk($sformatf("lsb_done%0d", i), l_done, i == 7);
      tick();
    end
    chk("lsb_idle_dout", l_dout, 1'b0);
    chk("lsb_idle_dv", l_dv, 1'b0);
    // hold-off: valid during bits 1..6 with changing data, 8'h3C offered on last bit
    w = 8'hA5;
    load_valid = 1'b1;
    data_in = w;
    tick();
    for (int i = 0; i < 8; i++) begin
      load_valid = (i != 6);
      data_in = (i == 7) ? 8'h3C : 8'h11 * (i + 1);
      #1;
      chk($sformatf("hold_ready%0d", i), m_ready, i == 7);
      chk($sformatf("hold_dout%0d", i), m_dout, w[7-i]);
      tick();
    end
    load_valid = 1'b0;
    data_in = 8'h00;
    shift_word("hold_next", 8'h3C);
    chk("hold_idle_dv", m_dv, 1'b0);
    // async reset during the 4th bit of 8'hFF
    load_valid = 1'b1;
    data_in = 8'hFF;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_dout_pre", m_dout, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_dout", m_dout, 1'b0);
    chk("mid_dv", m_dv, 1'b0);
    chk("mid_busy", m_busy, 1'b0);
    chk("mid_ready", m_ready, 1'b0);
    chk("mid_lsb_dv", l_dv, 1'b0);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rel_ready_pre", m_ready, 1'b0);
    chk("mid_rel_dout", m_dout, 1'b0);
    tick();
    chk("mid_rel_ready_post", m_ready, 1'b1);
    load_valid = 1'b1;
    data_in = 8'h5A;
    tick();
    load_valid = 1'b0;
    shift_word("fresh", 8'h5A);
    chk("fresh_idle_dv", m_dv, 1'b0);
    chk("fresh_idle_dout", m_dout, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
